sfft_readout_bridge: RTL

SFFT_READOUT_BRIDGE -- requirements
Module: sfft_readout_bridge

---
 rtl/sfft_readout_bridge.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sfft_readout_bridge.sv
// -----------------------------------------------------------------------------
// sfft_readout_bridge
//
// Byte-wide bus window onto the SFFT result memory, plus a frame counter and a
// lock handshake. While software holds the bridge LOCKED the pipeline is told
// (output_hold) not to overwrite the result memory, so a consistent frame can
// be read out. Frames that complete while locked are counted as drops.
//
// Word map (W = address[15:2], byte lane = address[1:0], lane 0 = LSB):
//   W <  NBINS*NUM_CHANNELS      : result bin {channel, bin}
//   W == NBINS*NUM_CHANNELS      : frame counter snapshot taken at lock
//   W == NBINS*NUM_CHANNELS + 1  : status {drop_count, 5'b0, overrun, locked, frame_valid}
//   otherwise                    : reads 0x00
// Writes to word 0 drive the lock: writedata[0]=1 locks, 0 unlocks.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   frame_done        one-cycle pulse per completed frame
//   bin_addr          result memory read address {channel, bin}
//   bin_data          result memory data, one cycle after bin_addr
//   output_hold       high while LOCKED
//   chipselect, read, write, address, writedata   bus request
//   readdata, readdatavalid                       read response, 1 cycle later
// -----------------------------------------------------------------------------
module sfft_readout_bridge #(
    parameter int NFFT_LOG2     = 9,
    parameter int NUM_CHANNELS  = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_done,
    output logic [NFFT_LOG2+1:0]   bin_addr,
    input  logic [DATA_WIDTH-1:0]  bin_data,
    output logic                   output_hold,
    input  logic                   chipselect,
    input  logic                   read,
    input  logic                   write,
    input  logic [15:0]            address,
    input  logic [7:0]             writedata,
    output logic [7:0]             readdata,
    output logic                   readdatavalid
);

    localparam int NBINS = 2 ** NFFT_LOG2;
    localparam logic [13:0] CNT_WORD  = 14'(NBINS * NUM_CHANNELS);
    localparam logic [13:0] STAT_WORD = 14'(NBINS * NUM_CHANNELS + 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    typedef enum logic [1:0] {
        REG_BIN  = 2'd0,
        REG_CNT  = 2'd1,
        REG_STAT = 2'd2,
        REG_ZERO = 2'd3
    } region_t;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Select one byte of a 32-bit little-endian word.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t                   state_r, state_next_s;
    logic [COUNTER_WIDTH-1:0] frame_count_r, frame_count_next_s;
    logic [COUNTER_WIDTH-1:0] count_snap_r;
    logic                     frame_valid_r;
    logic                     overrun_r;
    logic [7:0]               drop_count_r;

    logic [13:0]              word_s;
    logic [1:0]               lane_s;
    region_t                  region_s, region_r;
    logic [1:0]               lane_r;
    logic                     rd_accept_s;
    logic                     ctrl_wr_s;
    logic                     lock_evt_s, unlock_evt_s;
    logic [31:0]              cnt_word_s, stat_word_s;
    logic [7:0]               reg_byte_s, reg_byte_r;
    logic                     rdv_r;
    logic [NFFT_LOG2+1:0]     bin_addr_r;
    logic                     unused_s;

    assign word_s      = address[15:2];
    assign lane_s      = address[1:0];
    assign rd_accept_s = chipselect && read && !reset;
    assign ctrl_wr_s   = chipselect && write && (word_s == 14'd0);
    assign unused_s    = ^writedata[7:1];

    assign lock_evt_s   = (state_r == ST_UNLOCKED) && (state_next_s == ST_LOCKED);
    assign unlock_evt_s = (state_r == ST_LOCKED) && (state_next_s == ST_UNLOCKED);

    // The address goes straight to the memory on the accepting cycle so its data
    // is back in time for the one-cycle response; otherwise the last one is held.
    assign bin_addr = rd_accept_s ? address[NFFT_LOG2+3:2] : bin_addr_r;

    // Lock state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_UNLOCKED;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Lock next-state decode from control writes to word 0.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_UNLOCKED: begin
                if (ctrl_wr_s && writedata[0]) begin
                    state_next_s = ST_LOCKED;
                end else begin
                    state_next_s = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (ctrl_wr_s && !writedata[0]) begin
                    state_next_s = ST_UNLOCKED;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: state_next_s = ST_UNLOCKED;
        endcase
    end

    // Lock state outputs (decoded from the state register, so glitch-free).
    always_comb begin
        output_hold = 1'b0;
        case (state_r)
            ST_LOCKED: output_hold = 1'b1;
            default:   output_hold = 1'b0;
        endcase
    end

    // Frame count including a frame completing this cycle, so a coincident lock
    // captures a snapshot that already contains it.
    always_comb begin
        if (frame_done) begin
            frame_count_next_s = frame_count_r + CNT_ONE;
        end else begin
            frame_count_next_s = frame_count_r;
        end
    end

    // Frame bookkeeping: counter, snapshot, valid/overrun flags, drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_r <= '0;
            count_snap_r  <= '0;
            frame_valid_r <= 1'b0;
            overrun_r     <= 1'b0;
            drop_count_r  <= 8'h00;
        end else begin
            frame_count_r <= frame_count_next_s;
            if (lock_evt_s) begin
                count_snap_r <= frame_count_next_s;
            end else begin
                count_snap_r <= count_snap_r;
            end
            if (unlock_evt_s) begin
                // A frame finishing on the unlock cycle belongs to the new window.
                frame_valid_r <= frame_done;
                overrun_r     <= 1'b0;
                drop_count_r  <= 8'h00;
            end else if (frame_done && (state_r == ST_LOCKED)) begin
                frame_valid_r <= frame_valid_r;
                overrun_r     <= 1'b1;
                if (drop_count_r != 8'hFF) begin
                    drop_count_r <= drop_count_r + 8'd1;
                end else begin
                    drop_count_r <= drop_count_r;
                end
            end else if (frame_done) begin
                frame_valid_r <= 1'b1;
                overrun_r     <= overrun_r;
                drop_count_r  <= drop_count_r;
            end else begin
                frame_valid_r <= frame_valid_r;
                overrun_r     <= overrun_r;
                drop_count_r  <= drop_count_r;
            end
        end
    end

    assign cnt_word_s  = 32'(count_snap_r);
    assign stat_word_s = {16'h0000, drop_count_r, 5'b00000, overrun_r,
                          (state_r == ST_LOCKED), frame_valid_r};

    // Word region decode of the bus address.
    always_comb begin
        region_s = REG_ZERO;
        if (word_s < CNT_WORD) begin
            region_s = REG_BIN;
        end else if (word_s == CNT_WORD) begin
            region_s = REG_CNT;
        end else if (word_s == STAT_WORD) begin
            region_s = REG_STAT;
        end else begin
            region_s = REG_ZERO;
        end
    end

    // Byte of the internal registers addressed by the current request.
    always_comb begin
        reg_byte_s = 8'h00;
        case (region_s)
            REG_CNT:  reg_byte_s = byte_lane(cnt_word_s, lane_s);
            REG_STAT: reg_byte_s = byte_lane(stat_word_s, lane_s);
            default:  reg_byte_s = 8'h00;
        endcase
    end

    // Read request pipeline stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdv_r      <= 1'b0;
            region_r   <= REG_ZERO;
            lane_r     <= 2'd0;
            reg_byte_r <= 8'h00;
            bin_addr_r <= '0;
        end else if (rd_accept_s) begin
            rdv_r      <= 1'b1;
            region_r   <= region_s;
            lane_r     <= lane_s;
            reg_byte_r <= reg_byte_s;
            bin_addr_r <= address[NFFT_LOG2+3:2];
        end else begin
            rdv_r      <= 1'b0;
            region_r   <= region_r;
            lane_r     <= lane_r;
            reg_byte_r <= reg_byte_r;
            bin_addr_r <= bin_addr_r;
        end
    end

    // Response: bin bytes come from the memory data arriving this cycle (lanes
    // beyond DATA_WIDTH read zero via zero extension); other regions are registered.
    always_comb begin
        readdatavalid = rdv_r;
        if (!rdv_r) begin
            readdata = 8'h00;
        end else if (region_r == REG_BIN) begin
            readdata = byte_lane(32'(bin_data), lane_r);
        end else begin
            readdata = reg_byte_r;
        end
    end

endmodule
